// File: rtl/piso_tx_pkg.sv
// Shared serializer/deserializer definitions: FSM encodings and default widths.
package piso_tx_pkg;

   localparam int unsigned SERDES_WIDTH_DEFAULT = 8;

   // Parallel-in/serial-out transmitter states.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_e;

   // Serial-in/parallel-out receiver states, kept here so both ends share one file.
   typedef enum logic {
      SIPO_IDLE    = 1'b0,
      SIPO_CAPTURE = 1'b1
   } sipo_state_e;

endpackage : piso_tx_pkg

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with zero-latency first bit and gapless reload.
module piso_tx
   import piso_tx_pkg::*;
#(
   parameter int unsigned WIDTH     = SERDES_WIDTH_DEFAULT,
   parameter bit          LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             load,
   output logic             ready,
   output logic             serial_out,
   output logic             valid,
   output logic             done
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   piso_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             accept_c;
   logic             last_c;
   logic [WIDTH-1:0] shifted_c;

   // Status decodes of registered state; clr reaches them through the registers.
   assign last_c     = (cnt_q == '0);
   assign ready      = (state_q == IDLE) || last_c;
   assign valid      = (state_q == SHIFT);
   assign done       = (state_q == SHIFT) && last_c;
   assign serial_out = (state_q == SHIFT) &&
                       (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);
   assign accept_c   = load && ready;
   assign shifted_c  = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                 : {shreg_q[WIDTH-2:0], 1'b0};

   // Next-state: load on accept, otherwise advance one bit or fall back to idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (accept_c) begin
         state_d = SHIFT;
         cnt_d   = CNT_W'(WIDTH - 1);
         shreg_d = parallel_in;
      end else if (state_q == SHIFT) begin
         if (last_c) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
         end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            shreg_d = shifted_c;
         end
      end
   end

   // State, counter and shift register with asynchronous clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

endmodule : piso_tx
